// File: rtl/data_sram_responder_pkg.sv
// Shared encodings and entry types for the data SRAM responder.
// Size codes sit next to the load/store op indices used by the master side.
package data_sram_responder_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [2:0] {
    OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW
  } ls_op_e;

  typedef struct packed {
    logic        wr;
    logic [31:0] word;
  } resp_t;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/data_sram_responder_resp_fifo.sv
// In-order response queue: each entry carries its own latency countdown,
// and the head completes (and pops) as soon as its countdown reaches zero.
module resp_fifo
  import data_sram_responder_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int LATENCY = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         push_wr,
  input  logic [31:0]                  push_word,
  output logic                         head_ok,
  output logic                         head_wr,
  output logic [31:0]                  head_word,
  output logic [clog2_min1(DEPTH):0]   count
);

  localparam int PW = clog2_min1(DEPTH);
  localparam int CW = clog2_min1(LATENCY);
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [PW:0]   CNT_STEP = (PW + 1)'(1);

  logic [DEPTH-1:0]           vld_q, vld_d;
  resp_t [DEPTH-1:0]          ent_q, ent_d;
  logic [DEPTH-1:0][CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]              head_q, head_d, tail_q, tail_d;
  logic [PW:0]                count_q, count_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign head_ok   = vld_q[head_q] && (cnt_q[head_q] == '0);
  assign head_wr   = ent_q[head_q].wr;
  assign head_word = ent_q[head_q].word;
  assign count     = count_q;

  always_comb begin
    vld_d   = vld_q;
    ent_d   = ent_q;
    cnt_d   = cnt_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - CNT_ONE;
    end
    if (head_ok) begin
      vld_d[head_q] = 1'b0;
      head_d        = ptr_inc(head_q);
    end
    // Push after pop so a full queue can recycle the head slot in one edge.
    if (push) begin
      vld_d[tail_q] = 1'b1;
      ent_d[tail_q] = '{wr: push_wr, word: push_word};
      cnt_d[tail_q] = CNT_INIT;
      tail_d        = ptr_inc(tail_q);
    end
    case ({push, head_ok})
      2'b10:   count_d = count_q + CNT_STEP;
      2'b01:   count_d = count_q - CNT_STEP;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q   <= '0;
      ent_q   <= '0;
      cnt_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      vld_q   <= vld_d;
      ent_q   <= ent_d;
      cnt_q   <= cnt_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/data_sram_responder.sv
// Word-addressed data SRAM model with a pipelined req/addr_ok/data_ok handshake.
// Reads sample the array at acceptance; completions come back in order after LATENCY.
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int MEM_AW  = 10,
  parameter int DEPTH   = 2,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  input  logic        accept_stall,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata
);

  localparam int PW = clog2_min1(DEPTH);

  logic [31:0]       mem_q [0:(1 << MEM_AW) - 1];
  logic [MEM_AW-1:0] word_idx;
  logic [31:0]       rd_word;
  logic              accept;
  logic              head_ok, head_wr;
  logic [31:0]       head_word;
  logic [PW:0]       count;
  logic              unused_bits;

  // Size and sub-word address bits do not matter: the master extracts lanes.
  assign unused_bits = ^{data_sram_size, data_sram_addr[31:MEM_AW+2], data_sram_addr[1:0]};

  assign word_idx = data_sram_addr[MEM_AW+1:2];
  assign rd_word  = mem_q[word_idx];

  assign data_sram_addr_ok = resetn && data_sram_req && !accept_stall &&
                             ((count < (PW + 1)'(DEPTH)) || head_ok);
  assign accept            = data_sram_req && data_sram_addr_ok;
  assign data_sram_data_ok = resetn && head_ok;
  assign data_sram_rdata   = (data_sram_data_ok && !head_wr) ? head_word : '0;

  always_ff @(posedge clk) begin
    if (accept && data_sram_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_wstrb[i]) mem_q[word_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
      end
    end
  end

  resp_fifo #(.DEPTH(DEPTH), .LATENCY(LATENCY)) u_resp_fifo (
    .clk       (clk),
    .rst_n     (resetn),
    .push      (accept),
    .push_wr   (data_sram_wr),
    .push_word (data_sram_wr ? 32'h0 : rd_word),
    .head_ok   (head_ok),
    .head_wr   (head_wr),
    .head_word (head_word),
    .count     (count)
  );

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench: a LATENCY=1 instance driven from a vector table and a
// LATENCY=3 instance for full-queue and mid-flight reset sequences.
module tb_data_sram_responder;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic        req1, wr1, stall1, aok1, dok1;
  logic [1:0]  size1;
  logic [3:0]  wstrb1;
  logic [31:0] addr1, wdata1, rdata1;

  logic        req3, wr3, stall3, aok3, dok3;
  logic [1:0]  size3;
  logic [3:0]  wstrb3;
  logic [31:0] addr3, wdata3, rdata3;

  int checks = 0;
  int failures = 0;

  data_sram_responder u_l1 (
    .clk(clk), .resetn(resetn), .data_sram_req(req1), .data_sram_wr(wr1),
    .data_sram_size(size1), .data_sram_wstrb(wstrb1), .data_sram_addr(addr1),
    .data_sram_wdata(wdata1), .accept_stall(stall1), .data_sram_addr_ok(aok1),
    .data_sram_data_ok(dok1), .data_sram_rdata(rdata1)
  );

  data_sram_responder #(.MEM_AW(10), .DEPTH(2), .LATENCY(3)) u_l3 (
    .clk(clk), .resetn(resetn), .data_sram_req(req3), .data_sram_wr(wr3),
    .data_sram_size(size3), .data_sram_wstrb(wstrb3), .data_sram_addr(addr3),
    .data_sram_wdata(wdata3), .accept_stall(stall3), .data_sram_addr_ok(aok3),
    .data_sram_data_ok(dok3), .data_sram_rdata(rdata3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // One request on the LATENCY=1 instance: accepted at once, data_ok next cycle.
  task automatic l1_txn(input string nm, input vec_t v);
    @(posedge clk); #1;
    req1 = 1'b1; wr1 = v.wr; size1 = v.size; wstrb1 = v.wstrb;
    addr1 = v.addr; wdata1 = v.wdata;
    @(negedge clk);
    chk({nm, "_addr_ok"}, {31'd0, aok1}, 32'd1);
    chk({nm, "_early_data_ok"}, {31'd0, dok1}, 32'd0);
    @(posedge clk); #1;
    req1 = 1'b0;
    @(negedge clk);
    chk({nm, "_data_ok"}, {31'd0, dok1}, 32'd1);
    chk({nm, "_rdata"}, rdata1, v.exp);
  endtask

  // One request on the LATENCY=3 instance with bounded waits.
  task automatic l3_txn(input string nm, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp);
    int n;
    @(posedge clk); #1;
    req3 = 1'b1; wr3 = wr; addr3 = addr; wdata3 = wdata; wstrb3 = 4'hF; size3 = 2'd2;
    n = 0;
    @(negedge clk);
    while (!aok3 && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) chk({nm, "_accept_timeout"}, 32'd1, 32'd0);
    @(posedge clk); #1;
    req3 = 1'b0;
    n = 0;
    @(negedge clk);
    while (!dok3 && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) chk({nm, "_data_ok_timeout"}, 32'd1, 32'd0);
    else begin
      chk({nm, "_latency"}, n, 32'd2);
      chk({nm, "_rdata"}, rdata3, exp);
    end
  endtask

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{1'b1, 2'd2, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0};
    vecs[1]  = '{1'b0, 2'd2, 4'h0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 2'd2, 4'hF, 32'h0000_0020, 32'h1122_3344, 32'h0};
    vecs[3]  = '{1'b1, 2'd0, 4'h4, 32'h0000_0022, 32'hAAAA_AAAA, 32'h0};
    vecs[4]  = '{1'b0, 2'd0, 4'h0, 32'h0000_0022, 32'h0,         32'h11AA_3344};
    vecs[5]  = '{1'b1, 2'd2, 4'hF, 32'h0000_1004, 32'h0000_0005, 32'h0};
    vecs[6]  = '{1'b0, 2'd2, 4'h0, 32'h0000_0004, 32'h0,         32'h0000_0005};
    vecs[7]  = '{1'b1, 2'd2, 4'h0, 32'h0000_0010, 32'hFFFF_FFFF, 32'h0};
    vecs[8]  = '{1'b0, 2'd1, 4'h0, 32'h0000_0012, 32'h0,         32'hDEAD_BEEF};
    vecs[9]  = '{1'b1, 2'd2, 4'hF, 32'h0000_0024, 32'h1234_5678, 32'h0};
    vecs[10] = '{1'b1, 2'd1, 4'h3, 32'h0000_0024, 32'hCAFE_CAFE, 32'h0};

    resetn = 1'b0;
    req1 = 1'b1; wr1 = 1'b0; size1 = 2'd2; wstrb1 = 4'h0; addr1 = '0; wdata1 = '0; stall1 = 1'b0;
    req3 = 1'b1; wr3 = 1'b0; size3 = 2'd2; wstrb3 = 4'h0; addr3 = '0; wdata3 = '0; stall3 = 1'b0;

    // Reset state with a live request: nothing may be accepted or returned.
    @(negedge clk);
    chk("rst_addr_ok_l1", {31'd0, aok1}, 32'd0);
    chk("rst_data_ok_l1", {31'd0, dok1}, 32'd0);
    chk("rst_rdata_l1", rdata1, 32'd0);
    chk("rst_addr_ok_l3", {31'd0, aok3}, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1; req1 = 1'b0; req3 = 1'b0;

    for (int i = 0; i < 11; i++) l1_txn($sformatf("vec%0d", i), vecs[i]);
    l1_txn("wrap_read", '{1'b0, 2'd2, 4'h0, 32'hFFFF_F024, 32'h0, 32'h1234_CAFE});

    // Withdrawn request under stall must leave no trace.
    @(posedge clk); #1;
    req1 = 1'b1; wr1 = 1'b1; addr1 = 32'h10; wdata1 = 32'h0; wstrb1 = 4'hF; stall1 = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk($sformatf("stall_addr_ok_c%0d", c), {31'd0, aok1}, 32'd0);
      @(posedge clk); #1;
    end
    req1 = 1'b0; stall1 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("stall_no_data_ok_c%0d", c), {31'd0, dok1}, 32'd0);
    end
    l1_txn("stall_mem_intact", '{1'b0, 2'd2, 4'h0, 32'h10, 32'h0, 32'hDEAD_BEEF});

    // Preload the LATENCY=3 instance.
    l3_txn("pre_a", 1'b1, 32'h100, 32'hA0A0_0001, 32'h0);
    l3_txn("pre_b", 1'b1, 32'h104, 32'hB0B0_0002, 32'h0);
    l3_txn("pre_c", 1'b1, 32'h108, 32'hC0C0_0003, 32'h0);

    // Full queue: req held 4 cycles, third accepted in the first data_ok cycle.
    @(posedge clk); #1;
    req3 = 1'b1; wr3 = 1'b0; addr3 = 32'h100;
    @(negedge clk);
    chk("full_c0_addr_ok", {31'd0, aok3}, 32'd1);
    chk("full_c0_data_ok", {31'd0, dok3}, 32'd0);
    @(posedge clk); #1; addr3 = 32'h104;
    @(negedge clk);
    chk("full_c1_addr_ok", {31'd0, aok3}, 32'd1);
    @(posedge clk); #1; addr3 = 32'h108;
    @(negedge clk);
    chk("full_c2_addr_ok", {31'd0, aok3}, 32'd0);
    chk("full_c2_data_ok", {31'd0, dok3}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("full_c3_addr_ok", {31'd0, aok3}, 32'd1);
    chk("full_c3_data_ok", {31'd0, dok3}, 32'd1);
    chk("full_c3_rdata", rdata3, 32'hA0A0_0001);
    @(posedge clk); #1; req3 = 1'b0;
    @(negedge clk);
    chk("full_c4_data_ok", {31'd0, dok3}, 32'd1);
    chk("full_c4_rdata", rdata3, 32'hB0B0_0002);
    @(negedge clk);
    chk("full_c5_data_ok", {31'd0, dok3}, 32'd0);
    chk("full_c5_rdata", rdata3, 32'd0);
    @(negedge clk);
    chk("full_c6_data_ok", {31'd0, dok3}, 32'd1);
    chk("full_c6_rdata", rdata3, 32'hC0C0_0003);
    @(negedge clk);
    chk("full_c7_data_ok", {31'd0, dok3}, 32'd0);

    // Reset with two reads outstanding: their data_ok must never appear.
    @(posedge clk); #1;
    req3 = 1'b1; addr3 = 32'h100;
    @(negedge clk);
    chk("rstmid_c0_addr_ok", {31'd0, aok3}, 32'd1);
    @(posedge clk); #1; addr3 = 32'h104;
    @(negedge clk);
    chk("rstmid_c1_addr_ok", {31'd0, aok3}, 32'd1);
    @(posedge clk); #1; resetn = 1'b0;
    @(negedge clk);
    chk("rstmid_addr_ok", {31'd0, aok3}, 32'd0);
    chk("rstmid_data_ok", {31'd0, dok3}, 32'd0);
    chk("rstmid_rdata", rdata3, 32'd0);
    @(posedge clk); #1; resetn = 1'b1; req3 = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("rstmid_quiet_c%0d", c), {31'd0, dok3}, 32'd0);
    end
    l3_txn("post_rst_read", 1'b0, 32'h100, 32'h0, 32'hA0A0_0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
